// File: rtl/datapath_rf.sv
// Register file with r0 acting as the program counter, dual write ports,
// and a single-outstanding load tracker that flags hazards against its destination.
//
// state | meaning
// IDLE  | no load outstanding; ld_issue captures a destination
// PEND  | load outstanding to dst_q; waiting for ld_rvalid
module datapath_rf #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 16,
  parameter int              AW       = $clog2(NREG),
  parameter int unsigned     PC_STEP  = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_inc,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic [AW-1:0]   ra_a,
  input  logic [AW-1:0]   ra_b,
  input  logic [AW-1:0]   ra_c,
  input  logic [AW-1:0]   ra_d,
  output logic [XLEN-1:0] rd_a,
  output logic [XLEN-1:0] rd_b,
  output logic [XLEN-1:0] rd_c,
  output logic [XLEN-1:0] rd_d,
  input  logic            we1,
  input  logic            we2,
  input  logic [AW-1:0]   wa1,
  input  logic [AW-1:0]   wa2,
  input  logic [XLEN-1:0] wd1,
  input  logic [XLEN-1:0] wd2,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_dst,
  input  logic            ld_rvalid,
  input  logic [XLEN-1:0] ld_rdata,
  output logic            ld_busy,
  output logic            stall,
  output logic [XLEN-1:0] program_counter
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} ld_state_t;

  ld_state_t       state, nxt;
  logic [AW-1:0]   dst_q;
  logic [XLEN-1:0] regs [NREG];
  logic            ld_wr;
  logic            raw_hit, waw_hit;

  assign ld_wr = (state == PEND) && ld_rvalid;

  // Load tracker: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          dst_q <= '0;
    else if (state == IDLE && ld_issue)  dst_q <= ld_dst;
  end

  // Load tracker: next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (ld_issue)  nxt = PEND;
      PEND:    if (ld_rvalid) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Load tracker: outputs
  always_comb begin
    raw_hit = (ra_a == dst_q) || (ra_b == dst_q) || (ra_c == dst_q) || (ra_d == dst_q);
    waw_hit = (we1 && (wa1 == dst_q)) || (we2 && (wa2 == dst_q));
    ld_busy = (state == PEND);
    stall   = (state == PEND) && (raw_hit || waw_hit);
  end

  // r0 is the PC; loads never target it, so only the write ports compete below the PC controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs[0] <= RESET_PC;
      for (int i = 1; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (br_valid)                 regs[0] <= br_target;
      else if (pc_inc)              regs[0] <= regs[0] + XLEN'(PC_STEP);
      else if (we1 && wa1 == '0)    regs[0] <= wd1;
      else if (we2 && wa2 == '0)    regs[0] <= wd2;
      for (int i = 1; i < NREG; i++) begin
        if (ld_wr && dst_q == AW'(i))   regs[i] <= ld_rdata;
        else if (we1 && wa1 == AW'(i))  regs[i] <= wd1;
        else if (we2 && wa2 == AW'(i))  regs[i] <= wd2;
      end
    end
  end

  assign rd_a = (pc_inc && ra_a == '0) ? '0 : regs[ra_a];
  assign rd_b = (pc_inc && ra_b == '0) ? '0 : regs[ra_b];
  assign rd_c = (pc_inc && ra_c == '0) ? '0 : regs[ra_c];
  assign rd_d = (pc_inc && ra_d == '0) ? '0 : regs[ra_d];

  assign program_counter = regs[0];

endmodule

// File: tb/tb_datapath_rf.sv
// Directed bench for datapath_rf: PC update priority, dual-write arbitration,
// and the load tracker's busy/stall behaviour including reset mid-load.
module tb_datapath_rf;
  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int AW   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pc_inc, br_valid;
  logic [XLEN-1:0] br_target;
  logic [AW-1:0]   ra_a, ra_b, ra_c, ra_d;
  logic [XLEN-1:0] rd_a, rd_b, rd_c, rd_d;
  logic            we1, we2;
  logic [AW-1:0]   wa1, wa2;
  logic [XLEN-1:0] wd1, wd2;
  logic            ld_issue;
  logic [AW-1:0]   ld_dst;
  logic            ld_rvalid;
  logic [XLEN-1:0] ld_rdata;
  logic            ld_busy, stall;
  logic [XLEN-1:0] program_counter;

  int n_cmp = 0;
  int n_err = 0;

  datapath_rf #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .PC_STEP(1), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .pc_inc(pc_inc), .br_valid(br_valid), .br_target(br_target),
    .ra_a(ra_a), .ra_b(ra_b), .ra_c(ra_c), .ra_d(ra_d),
    .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c), .rd_d(rd_d),
    .we1(we1), .we2(we2), .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2),
    .ld_issue(ld_issue), .ld_dst(ld_dst), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .ld_busy(ld_busy), .stall(stall), .program_counter(program_counter)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_inc = 0; br_valid = 0; br_target = '0;
    we1 = 0; we2 = 0; wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0;
    ld_issue = 0; ld_dst = '0; ld_rvalid = 0; ld_rdata = '0;
  endtask

  // read a register through port a (pc_inc must be 0 for r0)
  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [XLEN-1:0] exp);
    ra_a = a;
    #1;
    chk(tag, rd_a, exp);
  endtask

  initial begin
    idle_inputs();
    ra_a = 4'd1; ra_b = 4'd2; ra_c = 4'd3; ra_d = 4'd4;
    rst_n = 0;
    #2;
    chk("rst_pc", program_counter, 32'h0);
    chk("rst_busy", {31'b0, ld_busy}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_r1", rd_a, 32'h0);
    tick();
    rst_n = 1;

    // PC increment
    pc_inc = 1; ra_a = '0;
    #1;
    chk("rd0_during_inc", rd_a, 32'h0);
    tick(); tick(); tick();
    pc_inc = 0;
    #1;
    chk("pc_after_3", program_counter, 32'h3);
    chk("rd0_after_inc", rd_a, 32'h3);

    // Branch beats increment and r0 write
    pc_inc = 1; br_valid = 1; br_target = 32'h100; we1 = 1; wa1 = '0; wd1 = 32'h55;
    tick();
    idle_inputs();
    #1;
    chk("branch_pc", program_counter, 32'h100);
    // plain architectural write to r0
    we1 = 1; wa1 = '0; wd1 = 32'h40;
    tick();
    idle_inputs();
    rd_chk("r0_arch_write", 4'd0, 32'h40);

    // Dual-write conflict and non-conflict
    we1 = 1; we2 = 1; wa1 = 4'd5; wa2 = 4'd5; wd1 = 32'hAA; wd2 = 32'hBB;
    tick();
    idle_inputs();
    rd_chk("dual_same_r5", 4'd5, 32'hAA);
    we1 = 1; we2 = 1; wa1 = 4'd5; wa2 = 4'd6; wd1 = 32'hAA; wd2 = 32'hBB;
    tick();
    idle_inputs();
    rd_chk("dual_diff_r5", 4'd5, 32'hAA);
    rd_chk("dual_diff_r6", 4'd6, 32'hBB);

    // Load hazard
    ra_a = 4'd1; ra_b = 4'd2; ra_c = 4'd3; ra_d = 4'd4;
    ld_issue = 1; ld_dst = 4'd7;
    #1;
    chk("busy_before_edge", {31'b0, ld_busy}, 32'h0);
    tick();
    idle_inputs();
    #1;
    chk("busy_pend", {31'b0, ld_busy}, 32'h1);
    chk("stall_no_hit", {31'b0, stall}, 32'h0);
    ra_b = 4'd7;
    #1;
    chk("stall_raw", {31'b0, stall}, 32'h1);
    ra_b = 4'd2; we2 = 1; wa2 = 4'd7;
    #1;
    chk("stall_waw", {31'b0, stall}, 32'h1);
    we2 = 0;
    // PC advances while load pending
    pc_inc = 1;
    tick();
    pc_inc = 0;
    #1;
    chk("pc_in_pend", program_counter, 32'h41);

    // Ignored issue in PEND
    ld_issue = 1; ld_dst = 4'd9;
    tick();
    idle_inputs();
    ra_a = 4'd9;
    #1;
    chk("dst_kept_no_r9", {31'b0, stall}, 32'h0);
    ra_a = 4'd7;
    #1;
    chk("dst_kept_r7", {31'b0, stall}, 32'h1);
    ra_b = 4'd7;
    ld_rvalid = 1; ld_rdata = 32'hDEAD;
    tick();
    idle_inputs();
    #1;
    chk("resp_busy", {31'b0, ld_busy}, 32'h0);
    chk("resp_stall", {31'b0, stall}, 32'h0);
    rd_chk("resp_r7", 4'd7, 32'hDEAD);
    rd_chk("resp_r9", 4'd9, 32'h0);

    // Response in IDLE ignored
    ld_rvalid = 1; ld_rdata = 32'h1234;
    tick();
    idle_inputs();
    rd_chk("idle_rvalid_r7", 4'd7, 32'hDEAD);

    // Load beats port 1 on collision; port 2 elsewhere still writes
    ld_issue = 1; ld_dst = 4'd8;
    tick();
    idle_inputs();
    ld_rvalid = 1; ld_rdata = 32'h11;
    we1 = 1; wa1 = 4'd8; wd1 = 32'h22;
    we2 = 1; wa2 = 4'd10; wd2 = 32'h33;
    tick();
    idle_inputs();
    rd_chk("ld_prio_r8", 4'd8, 32'h11);
    rd_chk("ld_prio_r10", 4'd10, 32'h33);

    // Reset mid-load
    ld_issue = 1; ld_dst = 4'd4;
    tick();
    idle_inputs();
    #1;
    chk("busy_r4", {31'b0, ld_busy}, 32'h1);
    rst_n = 0;
    #1;
    chk("rst_mid_busy", {31'b0, ld_busy}, 32'h0);
    chk("rst_mid_pc", program_counter, 32'h0);
    tick();
    rst_n = 1;
    ld_rvalid = 1; ld_rdata = 32'h55;
    tick();
    idle_inputs();
    rd_chk("rst_mid_r4", 4'd4, 32'h0);
    rd_chk("rst_mid_r7", 4'd7, 32'h0);
    chk("rst_mid_busy2", {31'b0, ld_busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
